osc_meas_sched: RTL and testbench

OSC_MEAS_SCHED -- requirements
Module: osc_meas_sched

---
 rtl/osc_meas_pkg.sv | 30 +++
 rtl/osc_sched_timer.sv | 28 ++
 rtl/osc_meas_sched.sv | 188 ++++++++++++++++++
 tb/tb_osc_meas_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_meas_pkg.sv
// Shared constants for the oscillator measurement scheduler: FSM encodings,
// default timing parameters and small elaboration-time helpers.
package osc_meas_pkg;

  localparam int GATE_CYC_DEF = 10_000_000;
  localparam int NUM_CH_DEF   = 3;
  localparam int STP_SMPL_DEF = 30;
  localparam int REST_CYC_DEF = 10_000_000;
  localparam int TMO_CYC_DEF  = 1024;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_GATE    = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;
  localparam logic [2:0] ST_REST    = 3'd6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_sched_timer.sv
// Loadable down-counter with a zero flag; one instance is time-shared by the
// gate, rest and handshake-timeout phases.
module osc_sched_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/osc_meas_sched.sv
// Sequencer for ring-oscillator frequency measurement: clear, gate, latch all
// channels, ship one UART frame, repeat STP_SMPL times, then rest halted.
module osc_meas_sched
  import osc_meas_pkg::*;
#(
  parameter int GATE_CYC = GATE_CYC_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int STP_SMPL = STP_SMPL_DEF,
  parameter int REST_CYC = REST_CYC_DEF,
  parameter int TMO_CYC  = TMO_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          enable,
  output logic                          osc_rst,
  output logic                          osc_halt,
  output logic                          latch_req,
  input  logic [NUM_CH-1:0]             latch_ack,
  output logic [NUM_CH-1:0]             ack_mask,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [width_of(STP_SMPL)-1:0] sample_idx,
  output logic                          tmo_err,
  output logic [2:0]                    state_dbg
);

  localparam int TW  = width_of(max3(GATE_CYC, REST_CYC, TMO_CYC));
  localparam int SIW = width_of(STP_SMPL);
  localparam logic [TW-1:0]  GATE_LD  = TW'(GATE_CYC - 1);
  localparam logic [TW-1:0]  REST_LD  = TW'(REST_CYC - 1);
  localparam logic [TW-1:0]  TMO_LD   = TW'(TMO_CYC - 1);
  localparam logic [SIW-1:0] LAST_IDX = SIW'(STP_SMPL - 1);

  // Handshakes: latch_req is held until every latch_ack bit has been seen
  // (bits may arrive on different cycles and need not stay high); tx_start is
  // a single-cycle request issued only while tx_busy is low, and the frame is
  // complete once tx_busy has gone high and then low again.

  logic [2:0]        state, nxt_state;
  logic [NUM_CH-1:0] ack_seen, nxt_ack_seen, ack_acc, nxt_ack_mask;
  logic              busy_seen, nxt_busy_seen;
  logic [SIW-1:0]    nxt_idx;
  logic              nxt_tmo, nxt_tx_start, tx_done;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]     tmr_val;

  osc_sched_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    nxt_state     = state;
    nxt_ack_seen  = ack_seen;
    nxt_ack_mask  = ack_mask;
    nxt_busy_seen = busy_seen;
    nxt_idx       = sample_idx;
    nxt_tmo       = tmo_err;
    nxt_tx_start  = 1'b0;
    tx_done       = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    tmr_dec       = 1'b0;
    ack_acc       = ack_seen | latch_ack;
    case (state)
      ST_IDLE: if (enable) nxt_state = ST_CLEAR;
      ST_CLEAR: begin
        if (!enable) begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
        end else begin
          nxt_state = ST_GATE;
          tmr_load  = 1'b1;
          tmr_val   = GATE_LD;
        end
      end
      ST_GATE: begin
        if (!enable) begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
        end else if (tmr_zero) begin
          nxt_state    = ST_LATCH;
          nxt_ack_seen = '0;
          tmr_load     = 1'b1;
          tmr_val      = TMO_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_LATCH: begin
        if (!enable) begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
        end else if (&ack_acc) begin
          nxt_state    = ST_SEND;
          nxt_ack_mask = ack_acc;
        end else if (tmr_zero) begin
          nxt_state    = ST_SEND;
          nxt_ack_mask = ack_acc;
          nxt_tmo      = 1'b1;
        end else begin
          nxt_ack_seen = ack_acc;
          tmr_dec      = 1'b1;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          nxt_state     = ST_WAIT_TX;
          nxt_tx_start  = 1'b1;
          nxt_busy_seen = 1'b0;
          tmr_load      = 1'b1;
          tmr_val       = TMO_LD;
        end
      end
      ST_WAIT_TX: begin
        // The timeout only guards a UART that never raises busy at all.
        if (busy_seen && !tx_busy) begin
          tx_done = 1'b1;
        end else if (!busy_seen && !tx_busy && tmr_zero) begin
          tx_done = 1'b1;
          nxt_tmo = 1'b1;
        end else begin
          if (tx_busy) nxt_busy_seen = 1'b1;
          if (!busy_seen) tmr_dec = 1'b1;
        end
        if (tx_done) begin
          if (!enable) begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
          end else if (sample_idx == LAST_IDX) begin
            nxt_state = ST_REST;
            nxt_idx   = '0;
            tmr_load  = 1'b1;
            tmr_val   = REST_LD;
          end else begin
            nxt_state = ST_CLEAR;
            nxt_idx   = sample_idx + 1'b1;
          end
        end
      end
      ST_REST: begin
        if (!enable) begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
        end else if (tmr_zero) begin
          nxt_state = ST_CLEAR;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      osc_rst    <= 1'b0;
      osc_halt   <= 1'b1;
      latch_req  <= 1'b0;
      tx_start   <= 1'b0;
      ack_mask   <= '0;
      ack_seen   <= '0;
      busy_seen  <= 1'b0;
      sample_idx <= '0;
      tmo_err    <= 1'b0;
    end else begin
      state      <= nxt_state;
      osc_rst    <= (nxt_state == ST_CLEAR);
      osc_halt   <= !((nxt_state == ST_CLEAR) || (nxt_state == ST_GATE));
      latch_req  <= (nxt_state == ST_LATCH);
      tx_start   <= nxt_tx_start;
      ack_mask   <= nxt_ack_mask;
      ack_seen   <= nxt_ack_seen;
      busy_seen  <= nxt_busy_seen;
      sample_idx <= nxt_idx;
      tmo_err    <= nxt_tmo;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_osc_meas_sched.sv
// Bench for osc_meas_sched: drives latch acks and a UART busy profile per
// sample and checks phase lengths, masks and flags against a sample-level model.
module tb_osc_meas_sched;

  localparam int GATE_CYC = 16;
  localparam int NUM_CH   = 3;
  localparam int STP_SMPL = 3;
  localparam int REST_CYC = 20;
  localparam int TMO_CYC  = 8;
  localparam int SIW      = $clog2(STP_SMPL);

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              enable = 1'b0;
  logic              osc_rst, osc_halt, latch_req, tx_start, tmo_err;
  logic [NUM_CH-1:0] latch_ack = '0;
  logic [NUM_CH-1:0] ack_mask;
  logic              tx_busy = 1'b0;
  logic [SIW-1:0]    sample_idx;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx  = 0;
  bit exp_tmo  = 1'b0;
  logic [NUM_CH-1:0] exp_q[$];

  osc_meas_sched #(
    .GATE_CYC (GATE_CYC),
    .NUM_CH   (NUM_CH),
    .STP_SMPL (STP_SMPL),
    .REST_CYC (REST_CYC),
    .TMO_CYC  (TMO_CYC)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .enable     (enable),
    .osc_rst    (osc_rst),
    .osc_halt   (osc_halt),
    .latch_req  (latch_req),
    .latch_ack  (latch_ack),
    .ack_mask   (ack_mask),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .sample_idx (sample_idx),
    .tmo_err    (tmo_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // One complete sample: d0..d2 = LATCH cycle (1-based) at which each ack
  // rises (beyond TMO_CYC means never), pre_busy = cycles the UART is still
  // busy after SEND entry, bdly/blen = busy profile after tx_start (bdly<0: never busy).
  task automatic do_sample(input string tag, input int d0, input int d1, input int d2,
                           input int pre_busy, input int bdly, input int blen, input bit drop_en);
    int d[3];
    int maxd, n_exp, n, s, g, c, ntx, exp_t, new_idx;
    bit wrap, ok;
    logic [NUM_CH-1:0] mexp;
    d[0] = d0; d[1] = d1; d[2] = d2;
    c = 0;
    while (osc_rst !== 1'b1 && c < 200) begin step(); c++; end
    if (osc_rst !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL %s clear_timeout actual none required osc_rst", tag);
      return;
    end
    chk({tag, " clear_halt"}, int'(osc_halt), 0);
    chk({tag, " clear_idx"}, int'(sample_idx), exp_idx);
    step();
    g = 0; ok = 1'b1;
    while (latch_req !== 1'b1 && g < 200) begin
      if (osc_halt !== 1'b0 || osc_rst !== 1'b0) ok = 1'b0;
      g++; step();
    end
    chk({tag, " gate_len"}, g, GATE_CYC);
    chk({tag, " gate_run"}, int'(ok), 1);

    maxd = 0;
    foreach (d[i]) if (d[i] > maxd) maxd = d[i];
    n_exp = (maxd <= TMO_CYC) ? maxd : TMO_CYC;
    mexp = '0;
    foreach (d[i]) if (d[i] <= n_exp) mexp[i] = 1'b1;
    exp_q.push_back(mexp);
    if (maxd > TMO_CYC) exp_tmo = 1'b1;
    n = 0;
    while (latch_req === 1'b1 && n < 50) begin
      n++;
      foreach (d[i]) latch_ack[i] = (n >= d[i]);
      tx_busy = (pre_busy > 0);
      step();
    end
    latch_ack = '0;
    chk({tag, " latch_len"}, n, n_exp);
    chk({tag, " ack_mask"}, int'(ack_mask), int'(exp_q.pop_front()));
    chk({tag, " tmo_err_latch"}, int'(tmo_err), int'(exp_tmo));
    chk({tag, " readout_halt"}, int'(osc_halt), 1);
    if (drop_en) enable = 1'b0;

    s = 1;
    while (tx_start !== 1'b1 && s < 50) begin
      tx_busy = (s <= pre_busy);
      step(); s++;
    end
    chk({tag, " tx_start_delay"}, s, pre_busy + 2);

    wrap    = (exp_idx == STP_SMPL - 1) && !drop_en;
    new_idx = (drop_en || exp_idx == STP_SMPL - 1) ? 0 : exp_idx + 1;
    exp_t   = (bdly < 0) ? TMO_CYC : bdly + blen + 1;
    if (bdly < 0) exp_tmo = 1'b1;
    ntx = 1;
    for (int t = 0; t <= exp_t; t++) begin
      if (t > 0 && tx_start === 1'b1) ntx++;
      if (t == exp_t - 1) begin
        chk({tag, " wait_idx_hold"}, int'(sample_idx), exp_idx);
        chk({tag, " wait_halt"}, int'(osc_halt), 1);
      end
      if (t == exp_t) begin
        chk({tag, " tx_pulses"}, ntx, 1);
        chk({tag, " next_idx"}, int'(sample_idx), new_idx);
        chk({tag, " next_osc_rst"}, int'(osc_rst), int'(!wrap && !drop_en));
        chk({tag, " next_halt"}, int'(osc_halt), int'(wrap || drop_en));
        chk({tag, " tmo_err_tx"}, int'(tmo_err), int'(exp_tmo));
      end else begin
        tx_busy = (bdly >= 0 && t >= bdly && t < bdly + blen);
        step();
      end
    end
    exp_idx = new_idx;

    if (wrap) begin
      c = 0; ok = 1'b1;
      while (osc_rst !== 1'b1 && c < 200) begin
        if (osc_halt !== 1'b1) ok = 1'b0;
        c++; step();
      end
      chk({tag, " rest_len"}, c, REST_CYC);
      chk({tag, " rest_halt"}, int'(ok), 1);
    end
    if (drop_en) begin
      ok = 1'b1;
      repeat (10) begin
        step();
        if (osc_rst !== 1'b0 || osc_halt !== 1'b1 || tx_start !== 1'b0 || sample_idx !== '0) ok = 1'b0;
      end
      chk({tag, " idle_after_tx"}, int'(ok), 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    chk("rst osc_halt", int'(osc_halt), 1);
    chk("rst osc_rst", int'(osc_rst), 0);
    chk("rst latch_req", int'(latch_req), 0);
    chk("rst tx_start", int'(tx_start), 0);
    chk("rst ack_mask", int'(ack_mask), 0);
    chk("rst sample_idx", int'(sample_idx), 0);
    chk("rst tmo_err", int'(tmo_err), 0);
    arst_n = 1'b1;
    step();
    chk("idle osc_halt", int'(osc_halt), 1);
    enable = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    do_sample("nominal", 3, 3, 3, 0, 0, 5, 1'b0);
  endtask

  task automatic test_staggered();
    do_sample("stagger", 1, 3, 5, 0, 1, 2, 1'b0);
  endtask

  task automatic test_run_wrap();
    do_sample("wrap", 1, 1, 1, 0, 0, 3, 1'b0);
  endtask

  task automatic test_busy_uart();
    do_sample("busy", 2, 1, 2, 4, 1, 3, 1'b0);
  endtask

  task automatic test_missing_ack();
    do_sample("missing", 2, 4, 99, 0, 0, 2, 1'b0);
  endtask

  task automatic test_random();
    int bd;
    for (int k = 0; k < 7; k++) begin
      bd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      do_sample($sformatf("rand%0d", k), int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
                int'($urandom_range(1, 10)), int'($urandom_range(0, 3)), bd,
                int'($urandom_range(1, 6)), 1'b0);
    end
  endtask

  task automatic test_disable_mid_gate();
    int c;
    c = 0;
    while (osc_rst !== 1'b1 && c < 200) begin step(); c++; end
    chk("dis_gate found_clear", int'(osc_rst), 1);
    repeat (6) step();
    chk("dis_gate running", int'(osc_halt), 0);
    enable = 1'b0;
    step();
    chk("dis_gate halt", int'(osc_halt), 1);
    chk("dis_gate latch_req", int'(latch_req), 0);
    chk("dis_gate idx", int'(sample_idx), 0);
    repeat (GATE_CYC) step();
    chk("dis_gate stays_idle", int'(osc_halt | latch_req | osc_rst), 1);
    exp_idx = 0;
    enable = 1'b1;
    step();
  endtask

  task automatic test_disable_in_send();
    do_sample("dis_send", 1, 2, 1, 1, 0, 2, 1'b1);
  endtask

  task automatic test_reset_in_wait_tx();
    int c;
    enable = 1'b1;
    c = 0;
    while (latch_req !== 1'b1 && c < 200) begin step(); c++; end
    chk("rst_wait found_latch", int'(latch_req), 1);
    latch_ack = '1;
    c = 0;
    while (tx_start !== 1'b1 && c < 50) begin step(); c++; end
    chk("rst_wait found_tx_start", int'(tx_start), 1);
    chk("rst_wait pre_mask", int'(ack_mask), 7);
    latch_ack = '0;
    #1 arst_n = 1'b0;
    #1;
    chk("rst_wait tx_start", int'(tx_start), 0);
    chk("rst_wait osc_halt", int'(osc_halt), 1);
    chk("rst_wait osc_rst", int'(osc_rst), 0);
    chk("rst_wait latch_req", int'(latch_req), 0);
    chk("rst_wait ack_mask", int'(ack_mask), 0);
    chk("rst_wait idx", int'(sample_idx), 0);
    chk("rst_wait tmo_err", int'(tmo_err), 0);
    step();
    arst_n = 1'b1;
    c = 0;
    repeat (12) begin
      step();
      if (tx_start !== 1'b0) c++;
    end
    chk("rst_wait no_tx_start", c, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_staggered();
    test_run_wrap();
    test_busy_uart();
    test_missing_ack();
    test_random();
    test_disable_mid_gate();
    test_disable_in_send();
    test_reset_in_wait_tx();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
